// File: rtl/kmac_err_capture.sv
// KMAC error capture: fixed-priority pick among sources, hold first error until SW ack,
// count drops while held, sticky fatal on any source FSM fault.
// Each src_err_i lane is packed {valid[32], code[31:24], info[23:0]}.
module kmac_err_capture #(
   parameter int NumSrc = 3,
   parameter int CntW   = 8,
   localparam int SrcW  = (NumSrc > 1) ? $clog2(NumSrc) : 1
) (
   input  logic                   clk_i,
   input  logic                   rst_ni,
   input  logic [NumSrc-1:0][32:0] src_err_i,
   input  logic [NumSrc-1:0]      src_fsm_err_i,
   input  logic                   err_clr_i,
   output logic                   err_valid_o,
   output logic [31:0]            err_code_o,
   output logic [SrcW-1:0]        err_src_o,
   output logic                   err_event_o,
   output logic [CntW-1:0]        drop_cnt_o,
   output logic                   overflow_o,
   output logic                   fatal_alert_o
);

   localparam logic [CntW-1:0] DropMax = '1;

   typedef enum logic [1:0] {
      StEmpty = 2'b01,
      StHeld  = 2'b10
   } state_e;

   state_e            state_q, state_d;
   logic              any_err;
   logic [SrcW-1:0]   win_idx;
   logic [31:0]       win_code;
   logic [31:0]       code_d;
   logic [SrcW-1:0]   src_d;
   logic              event_d;
   logic [CntW-1:0]   drop_d;
   logic              ovf_d;

   // Scan from the lowest priority upward so index 0 wins last.
   always_comb begin
      any_err  = 1'b0;
      win_idx  = '0;
      win_code = '0;
      for (int i = NumSrc - 1; i >= 0; i--) begin
         if (src_err_i[i][32]) begin
            any_err  = 1'b1;
            win_idx  = SrcW'(i);
            win_code = src_err_i[i][31:0];
         end
      end
   end

   always_comb begin
      state_d = state_q;
      code_d  = err_code_o;
      src_d   = err_src_o;
      event_d = 1'b0;
      drop_d  = drop_cnt_o;
      ovf_d   = overflow_o;
      if (err_clr_i) begin
         drop_d = '0;
         ovf_d  = 1'b0;
      end
      case (state_q)
         StEmpty: begin
            if (any_err) begin
               state_d = StHeld;
               code_d  = win_code;
               src_d   = win_idx;
               event_d = 1'b1;
            end
         end
         StHeld: begin
            if (err_clr_i) begin
               // Clear takes effect first; a same-cycle error is a fresh capture.
               if (any_err) begin
                  code_d  = win_code;
                  src_d   = win_idx;
                  event_d = 1'b1;
               end else begin
                  state_d = StEmpty;
                  code_d  = '0;
                  src_d   = '0;
               end
            end else if (any_err) begin
               if (drop_cnt_o == DropMax) ovf_d = 1'b1;
               else drop_d = drop_cnt_o + 1'b1;
            end
         end
         default: begin
            state_d = StEmpty;
            code_d  = '0;
            src_d   = '0;
         end
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q       <= StEmpty;
         err_valid_o   <= 1'b0;
         err_code_o    <= '0;
         err_src_o     <= '0;
         err_event_o   <= 1'b0;
         drop_cnt_o    <= '0;
         overflow_o    <= 1'b0;
         fatal_alert_o <= 1'b0;
      end else begin
         state_q       <= state_d;
         err_valid_o   <= (state_d == StHeld);
         err_code_o    <= code_d;
         err_src_o     <= src_d;
         err_event_o   <= event_d;
         drop_cnt_o    <= drop_d;
         overflow_o    <= ovf_d;
         fatal_alert_o <= fatal_alert_o | (|src_fsm_err_i);
      end
   end

endmodule

// File: doc/kmac_err_capture.md
# kmac_err_capture

Error capture and reporting stage that sits directly downstream of the KMAC error checker and the other KMAC error sources. Each cycle it takes the `err_t` records from all sources and arbitrates them by fixed priority. It latches the first error into the software-visible ERR_CODE value, raises a one-cycle event toward the interrupt logic, and holds the captured error until software acknowledges it. Errors that arrive while one is held are counted as dropped. A sparse-FSM fault is latched into a sticky fatal alert.

## Interface
- `NumSrc`, default 3: number of error sources; index 0 has the highest priority (index 0 = errchk, 1 = app, 2 = core).
- `CntW`, default 8: width of the dropped-error counter.

Ports:
- `clk_i`  in  1  clock; single clock domain.
- `rst_ni`  in  1  reset; asynchronous, active-low.
- `src_err_i`  in  NumSrc x err_t  per-source error record: valid (1b), code (8b), info (24b).
- `src_fsm_err_i`  in  NumSrc  per-source sparse-FSM error flags.
- `err_clr_i`  in  1  SW acknowledge pulse (W1C of INTR_STATE.kmac_err).
- `err_valid_o`  out  1  a captured error is held.
- `err_code_o`  out  32  ERR_CODE value, `{code[7:0], info[23:0]}`.
- `err_src_o`  out  $clog2(NumSrc)  index of the source that was captured.
- `err_event_o`  out  1  one-cycle pulse when a new error is captured.
- `drop_cnt_o`  out  CntW  saturating count of errors lost while holding.
- `overflow_o`  out  1  sticky; set when `drop_cnt_o` is at saturation and another drop occurs.
- `fatal_alert_o`  out  1  sticky OR of all `src_fsm_err_i`.

## Operation
- Arbitration:
  - Each cycle, the winner is the lowest index `i` with `src_err_i[i].valid`.
  - `any_err` = OR of all valid bits.
  - Losing sources in the same cycle are not counted as drops.
- FSM states are StEmpty and StHeld. Encoding is internal; StHeld is never entered from an unknown state.
- StEmpty:
  - If `any_err`: latch the winner's `{code, info}` into `err_code_o` and its index into `err_src_o`, pulse `err_event_o`, go to StHeld.
  - `err_clr_i` is ignored.
- StHeld:
  - `err_code_o` and `err_src_o` are frozen.
  - If `err_clr_i` and `any_err` in the same cycle: the clear is applied first, then the new winner is captured, `err_event_o` pulses, and the state stays StHeld. No drop is counted.
  - If `err_clr_i` alone: go to StEmpty and clear `err_code_o` and `err_src_o` to 0.
  - If `any_err` alone: the error is dropped; `drop_cnt_o` increments by 1 per cycle with `any_err`.
- Level semantics: every cycle a valid bit is high counts as one error event. Sources present single-cycle pulses.
- `drop_cnt_o` saturation:
  - Saturates at 2^CntW-1 and does not wrap.
  - A drop while saturated sets `overflow_o`.
  - `err_clr_i` clears both `drop_cnt_o` and `overflow_o` in every state, including the clear+capture cycle.
- `fatal_alert_o`:
  - Set in the cycle after any `src_fsm_err_i` bit is high.
  - Cleared only by reset; `err_clr_i` has no effect on it.
  - Error capture keeps operating normally while it is set.
- `info` and `code` are passed through unmodified. There is no width conversion beyond the `{code, info}` concatenation.

## Timing
- Reset values:
  - FSM = StEmpty.
  - `err_valid_o` = 0, `err_code_o` = 0, `err_src_o` = 0, `err_event_o` = 0, `drop_cnt_o` = 0, `overflow_o` = 0, `fatal_alert_o` = 0.
- All outputs are registered. There is no combinational path from any input to any output.
- Capture latency is 1 cycle: a valid at edge N makes `err_valid_o`, `err_code_o` and `err_event_o` visible after edge N, in the same cycle.
- `err_event_o` is high for exactly one cycle per capture.
- Clear latency is 1 cycle: `err_clr_i` at edge N drops `err_valid_o` after edge N. An error at edge N+1 is captured normally.
- Reset mid-operation: asynchronous assertion forces all outputs to their reset values immediately. No pending event is replayed after release.

## Test plan
- **Single capture:** src0 presents valid, code=0x02, info=0x000123 for 1 cycle → next cycle:
  - `err_valid_o`=1, `err_code_o`=0x02000123, `err_src_o`=0;
  - `err_event_o` high for exactly 1 cycle.
- **Priority:** src1 (code 0x05) and src2 (code 0x80) valid in the same cycle → `err_src_o`=1, `err_code_o[31:24]`=0x05, `drop_cnt_o`=0.
- **Drops while held:** capture, then 3 single-cycle src2 errors →
  - `drop_cnt_o`=3, `err_code_o` unchanged, no further `err_event_o`;
  - `err_clr_i` → `err_valid_o`=0, `drop_cnt_o`=0.
- **Saturation:** CntW=2, capture, then 4 drops → `drop_cnt_o`=3 and `overflow_o`=1 after the 4th; `err_clr_i` clears both.
- **Clear + new error in the same cycle:** while holding code 0x02, `err_clr_i` and src0 code 0x03 arrive together →
  - `err_code_o[31:24]`=0x03, `err_event_o` pulses;
  - `err_valid_o` stays 1, `drop_cnt_o`=0.
- **Fatal and reset:**
  - `src_fsm_err_i[0]` high 1 cycle → `fatal_alert_o`=1; it persists through `err_clr_i`.
  - Async `rst_ni` low mid-hold → all outputs 0 immediately.
